// File: rtl/system_tx_sequencer.sv
// Transmit sequencer: queues datapath result words and serialises them, low byte first, to a UART TX core.
// Optional length-header byte before each frame is enabled by defining SYSTEM_TX_SEQ_LEN_HEADER_EN.
module system_tx_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [2*DATA_WIDTH-1:0] i_word,
    input  logic                    i_word_len,
    input  logic                    i_word_valid,
    output logic                    o_full,
    output logic                    o_drop,
    output logic [DATA_WIDTH-1:0]   o_tx_byte,
    output logic                    o_tx_valid,
    input  logic                    i_tx_busy,
    output logic                    o_idle
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORD_W = 2 * DATA_WIDTH;
    localparam int TMR_W  = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
`ifdef SYSTEM_TX_SEQ_LEN_HEADER_EN
        , HEADER
`endif
    } state_t;

    state_t state;

    logic [WORD_W:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_next;
    logic                 push_ok;
    logic                 pop;
    logic                 fifo_empty;
    logic [WORD_W:0]      head;

    logic [WORD_W-1:0]    frame_word;
    logic                 byte_idx;
    logic                 next_idx;
    logic [1:0]           bytes_left;
    logic [TMR_W-1:0]     timer;
`ifdef SYSTEM_TX_SEQ_LEN_HEADER_EN
    logic                 header_pending;
`endif

    assign o_full     = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push_ok    = i_word_valid && !o_full;
    assign pop        = (state == LOAD);
    assign head       = mem[rd_ptr];
    assign next_idx   = byte_idx + 1'b1;

    always_comb begin
        count_next = count;
        if (push_ok && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (!push_ok && pop) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {i_word_len, i_word};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            o_drop <= 1'b0;
        end else begin
            count  <= count_next;
            o_drop <= i_word_valid && o_full;
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // The byte and strobe are loaded on the edge entering SEND so they are visible while in SEND.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            frame_word <= '0;
            byte_idx   <= 1'b0;
            bytes_left <= 2'd0;
            timer      <= '0;
            o_tx_byte  <= '0;
            o_tx_valid <= 1'b0;
            o_idle     <= 1'b1;
`ifdef SYSTEM_TX_SEQ_LEN_HEADER_EN
            header_pending <= 1'b0;
`endif
        end else begin
            o_tx_valid <= 1'b0;
            o_idle     <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty && !i_tx_busy) begin
                        state <= LOAD;
                    end else begin
                        o_idle <= (count_next == '0);
                    end
                end
                LOAD: begin
                    frame_word <= head[WORD_W-1:0];
                    byte_idx   <= 1'b0;
                    bytes_left <= head[WORD_W] ? 2'd1 : 2'd2;
                    o_tx_valid <= 1'b1;
`ifdef SYSTEM_TX_SEQ_LEN_HEADER_EN
                    o_tx_byte      <= head[WORD_W] ? DATA_WIDTH'(1) : DATA_WIDTH'(2);
                    header_pending <= 1'b1;
                    state          <= HEADER;
`else
                    o_tx_byte <= head[DATA_WIDTH-1:0];
                    state     <= SEND;
`endif
                end
`ifdef SYSTEM_TX_SEQ_LEN_HEADER_EN
                SEND, HEADER: begin
`else
                SEND: begin
`endif
                    timer <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (i_tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (timer == TMR_W'(BUSY_TIMEOUT - 1)) begin
                        o_tx_valid <= 1'b1;
                        state      <= SEND;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!i_tx_busy) begin
`ifdef SYSTEM_TX_SEQ_LEN_HEADER_EN
                        if (header_pending) begin
                            header_pending <= 1'b0;
                            o_tx_byte      <= frame_word[DATA_WIDTH-1:0];
                            o_tx_valid     <= 1'b1;
                            state          <= SEND;
                        end else
`endif
                        if (bytes_left == 2'd1) begin
                            bytes_left <= 2'd0;
                            if (!fifo_empty) begin
                                state <= LOAD;
                            end else begin
                                state  <= IDLE;
                                o_idle <= !push_ok;
                            end
                        end else begin
                            bytes_left <= bytes_left - 2'd1;
                            byte_idx   <= next_idx;
                            o_tx_byte  <= frame_word[int'(next_idx) * DATA_WIDTH +: DATA_WIDTH];
                            o_tx_valid <= 1'b1;
                            state      <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_system_tx_sequencer.sv
// Scoreboard bench for system_tx_sequencer: directed pushes, a reactive UART TX model and a byte monitor.
module tb_system_tx_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] word;
    logic        word_len;
    logic        word_valid;
    logic        tx_busy;
    logic        full;
    logic        drop;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        idle;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rx_count = 0;

    logic [7:0] exp_q [$];

    bit hold_busy = 1'b0;
    int ignore_n = 0;
    bit pending = 1'b0;
    int busy_left = 0;

    system_tx_sequencer dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_word       (word),
        .i_word_len   (word_len),
        .i_word_valid (word_valid),
        .o_full       (full),
        .o_drop       (drop),
        .o_tx_byte    (tx_byte),
        .o_tx_valid   (tx_valid),
        .i_tx_busy    (tx_busy),
        .o_idle       (idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // UART TX model: busy rises one cycle after an accepted strobe and stays high 10 cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_busy) begin
                tx_busy   = 1'b1;
                pending   = 1'b0;
                busy_left = 0;
            end else if (pending) begin
                pending   = 1'b0;
                tx_busy   = 1'b1;
                busy_left = 10;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) tx_busy = 1'b0;
            end else begin
                tx_busy = 1'b0;
            end
            if (!hold_busy && tx_valid) begin
                if (ignore_n > 0) ignore_n--;
                else pending = 1'b1;
            end
        end
    end

    // Monitor: every byte strobe must match the oldest expected byte.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_valid) begin
                rx_count++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_byte", {24'd0, tx_byte}, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("tx_byte", {24'd0, tx_byte}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // Called at a negedge; returns at the next negedge with the strobe removed.
    task automatic applyStimulus(input logic [15:0] w, input logic len, input bit expect_drop,
                                 input bit dup_first);
        logic [7:0] first;
        word       = w;
        word_len   = len;
        word_valid = 1'b1;
        if (!expect_drop) begin
`ifdef SYSTEM_TX_SEQ_LEN_HEADER_EN
            first = len ? 8'h01 : 8'h02;
            exp_q.push_back(first);
            if (dup_first) exp_q.push_back(first);
            exp_q.push_back(w[7:0]);
`else
            first = w[7:0];
            exp_q.push_back(first);
            if (dup_first) exp_q.push_back(first);
`endif
            if (!len) exp_q.push_back(w[15:8]);
        end
        @(negedge clk);
        word_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget, input string name, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (tx_valid) begin
                at_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (at_cyc < 0) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (idle && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput({name, "_idle_reached"}, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int t0;
        int t1;
        int push_cyc;
        int seen;

        rst        = 1'b1;
        word       = '0;
        word_len   = 1'b0;
        word_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
        checkOutput("reset_tx_byte", {24'd0, tx_byte}, 32'd0);
        checkOutput("reset_idle", {31'd0, idle}, 32'd1);
        checkOutput("reset_drop", {31'd0, drop}, 32'd0);
        checkOutput("reset_full", {31'd0, full}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Two-byte frame with first-byte latency check.
        push_cyc = cyc;
        applyStimulus(16'hBEEF, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_after_push", {31'd0, idle}, 32'd0);
        wait_valid(20, "first_byte", t0);
        checkOutput("first_byte_latency", t0 - push_cyc, 32'd3);
        wait_idle(80, "beef");
        checkOutput("busy_low_at_idle", {31'd0, tx_busy}, 32'd0);

        // One-byte frame; monitor flags any extra strobe.
        applyStimulus(16'h12AB, 1'b1, 1'b0, 1'b0);
        wait_idle(60, "one_byte");
        repeat (20) @(negedge clk);
        checkOutput("one_byte_still_idle", {31'd0, idle}, 32'd1);

        // Fill while the UART is busy, overflow once, then drain in order.
        hold_busy = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(16'h1101, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'h2202, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'h3303, 1'b0, 1'b0, 1'b0);
        checkOutput("not_full_at_3", {31'd0, full}, 32'd0);
        applyStimulus(16'h4404, 1'b0, 1'b0, 1'b0);
        checkOutput("full_at_4", {31'd0, full}, 32'd1);
        checkOutput("no_drop_before_5th", {31'd0, drop}, 32'd0);
        applyStimulus(16'h5505, 1'b0, 1'b1, 1'b0);
        checkOutput("drop_pulse", {31'd0, drop}, 32'd1);
        @(negedge clk);
        checkOutput("drop_one_cycle", {31'd0, drop}, 32'd0);
        checkOutput("no_tx_while_held", rx_count, 32'd3);
        hold_busy = 1'b0;
        wait_idle(400, "drain");

        // UART ignores the first strobe: same byte re-pulsed after the timeout.
        ignore_n = 1;
        applyStimulus(16'h7788, 1'b0, 1'b0, 1'b1);
        wait_valid(20, "retx_first", t0);
        @(negedge clk);
        wait_valid(20, "retx_second", t1);
        checkOutput("retx_gap", t1 - t0, 32'd5);
        wait_idle(120, "retx");

        // Reset mid-frame while the first byte is in WAIT_DONE.
        applyStimulus(16'h5566, 1'b0, 1'b0, 1'b0);
        wait_valid(20, "pre_reset", t0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        exp_q.delete();
        checkOutput("midreset_tx_valid", {31'd0, tx_valid}, 32'd0);
        checkOutput("midreset_tx_byte", {24'd0, tx_byte}, 32'd0);
        checkOutput("midreset_idle", {31'd0, idle}, 32'd1);
        checkOutput("midreset_full", {31'd0, full}, 32'd0);
        seen = rx_count;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("no_byte_after_reset", rx_count, seen);
        checkOutput("idle_after_reset", {31'd0, idle}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
